// File: rtl/comp_bist.sv
// Self-test sweeper/checker for the comp magnitude comparator.
// Build option: COMP_BIST_STOP_ON_FAIL_EN ends the sweep on the first mismatch.
module comp_bist #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic             gtr_in,
    input  logic             eq_in,
    input  logic             less_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [2:0]       fail_got
);

    localparam int IW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [IW-1:0]    idx, idx_n;
    logic [7:0]       cnt, cnt_n;
    logic [ERR_W-1:0] err_n;
    logic             fv_n, busy_n, done_n;
    logic [WIDTH-1:0] fa_n, fb_n;
    logic [2:0]       fg_n;
    logic [WIDTH-1:0] cur_a, cur_b;
    logic [2:0]       got, exp_res;
    logic             mism, last, sample, stop;

    assign cur_a   = idx[IW-1:WIDTH];
    assign cur_b   = idx[WIDTH-1:0];
    assign a_out   = cur_a;
    assign b_out   = cur_b;
    assign exp_res = {cur_a > cur_b, cur_a == cur_b, cur_a < cur_b};
    assign got     = {gtr_in, eq_in, less_in};
    assign mism    = (got != exp_res);
    assign last    = (idx == {IW{1'b1}});
    assign sample  = (cnt == 8'(SETTLE));
    assign pass    = done && (err_count == '0);

`ifdef COMP_BIST_STOP_ON_FAIL_EN
    assign stop = last || mism;
`else
    assign stop = last;
`endif

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        err_n   = err_count;
        fv_n    = fail_valid;
        fa_n    = fail_a;
        fb_n    = fail_b;
        fg_n    = fail_got;
        busy_n  = busy;
        done_n  = done;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = RUN;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    err_n   = '0;
                    fv_n    = 1'b0;
                    fa_n    = '0;
                    fb_n    = '0;
                    fg_n    = '0;
                    idx_n   = '0;
                    cnt_n   = 8'd1;
                end
            end
            RUN: begin
                if (sample) begin
                    if (mism) begin
                        if (err_count != {ERR_W{1'b1}})
                            err_n = err_count + 1'b1;
                        // only the first failing vector is kept
                        if (!fail_valid) begin
                            fv_n = 1'b1;
                            fa_n = cur_a;
                            fb_n = cur_b;
                            fg_n = got;
                        end
                    end
                    if (stop) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
                        cnt_n = 8'd1;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_got   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            err_count  <= err_n;
            fail_valid <= fv_n;
            fail_a     <= fa_n;
            fail_b     <= fb_n;
            fail_got   <= fg_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_comp_bist.sv
// Directed bench for comp_bist: two instances (1-bit/ERR_W=2 and 2-bit/SETTLE=3)
// driven against a behavioural comparator with selectable faults.
module tb_comp_bist;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0;
    logic start2 = 1'b0;
    int   mode1 = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

`ifdef COMP_BIST_STOP_ON_FAIL_EN
    localparam int EQ_ERR = 1, EQ_CYC = 4 - 3, EQ_AB = 0, INV_ERR = 1;
`else
    localparam int EQ_ERR = 2, EQ_CYC = 4, EQ_AB = 3, INV_ERR = 3;
`endif

    logic       a1, b1, g1, e1, l1, busy1, done1, pass1, fv1, fa1, fb1;
    logic [1:0] err1;
    logic [2:0] fg1;

    logic [1:0] a2, b2, fa2, fb2;
    logic       g2, e2, l2, busy2, done2, pass2, fv2;
    logic [7:0] err2;
    logic [2:0] fg2;

    // mode 0 correct, 1 eq stuck at 0, 2 all outputs inverted
    always_comb begin
        g1 = a1 > b1;
        e1 = a1 == b1;
        l1 = a1 < b1;
        if (mode1 == 1) e1 = 1'b0;
        if (mode1 == 2) {g1, e1, l1} = ~{g1, e1, l1};
    end

    assign g2 = a2 > b2;
    assign e2 = a2 == b2;
    assign l2 = a2 < b2;

    comp_bist #(.WIDTH(1), .SETTLE(1), .ERR_W(2)) d1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a_out(a1), .b_out(b1),
        .gtr_in(g1), .eq_in(e1), .less_in(l1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_valid(fv1),
        .fail_a(fa1), .fail_b(fb1), .fail_got(fg1)
    );

    comp_bist #(.WIDTH(2), .SETTLE(3), .ERR_W(8)) d2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .a_out(a2), .b_out(b2),
        .gtr_in(g2), .eq_in(e2), .less_in(l2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_valid(fv2),
        .fail_a(fa2), .fail_b(fb2), .fail_got(fg2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic run1(output int n);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic sweep2(input string tag, input bit poke);
        int c;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        c = 0;
        while (!done2 && c < 300) begin
            if (c < 48) chk({tag, "_seq"}, {a2, b2}, c / 3);
            if (poke && c == 10) start2 = 1'b1;
            tick();
            start2 = 1'b0;
            c++;
        end
        chk({tag, "_cycles"}, c, 48);
        chk({tag, "_last"}, {a2, b2}, 4'hf);
        chk({tag, "_pass"}, {busy2, done2, pass2, fv2}, 4'b0110);
        chk({tag, "_err"}, err2, 0);
    endtask

    initial begin
        int n;
        tick();
        tick();
        chk("rst1", {a1, b1, busy1, done1, pass1, err1, fv1, fa1, fb1, fg1}, 0);
        chk("rst2", {a2, b2, busy2, done2, pass2, err2, fv2, fa2, fb2, fg2}, 0);
        rst_n = 1'b1;
        tick();
        chk("idle1", {busy1, done1}, 0);

        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("seq1", {busy1, a1, b1}, 4 + i);
            tick();
        end
        chk("done1", {busy1, done1, pass1, err1, fv1}, 6'b011000);
        chk("hold1", {a1, b1}, 3);

        mode1 = 1;
        run1(n);
        chk("eq_cyc", n, EQ_CYC);
        chk("eq_err", err1, EQ_ERR);
        chk("eq_flag", {done1, pass1, fv1}, 3'b101);
        chk("eq_cap", {fa1, fb1, fg1}, 0);
        chk("eq_ab", {a1, b1}, EQ_AB);

        mode1 = 2;
        run1(n);
        chk("inv_err", err1, INV_ERR);
        chk("inv_cap", {fv1, fa1, fb1, fg1}, 6'b100101);
        chk("inv_pass", pass1, 0);

        mode1 = 0;
        run1(n);
        chk("clean1", {done1, pass1, err1, fv1, fg1}, 8'b11000000);

        sweep2("sw", 1'b1);

        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_busy", {busy2, a2, b2}, 5'b10001);
        rst_n = 1'b0;
        start2 = 1'b1;
        tick();
        chk("mrst2", {a2, b2, busy2, done2, pass2, err2, fv2, fa2, fb2, fg2}, 0);
        chk("mrst1", {a1, b1, busy1, done1, pass1, err1, fv1, fa1, fb1, fg1}, 0);
        rst_n = 1'b1;
        start2 = 1'b0;
        tick();
        chk("post_rst", {busy2, done2}, 0);

        sweep2("re", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comp_bist.md
Name: comp_bist

Overview:
- Self-test driver/checker for the `comp` magnitude comparator (outputs GTR/EQ/LESS); it sits at the opposite end of the comparator interface.
- Sweeps every {A,B} operand pair on its drive outputs, waits a settle window, samples the comparator's three outputs and checks them against the expected one-hot result.
- Reports busy/done, pass/fail, a saturating error count and the first failing vector.
- Lets the comparator be exercised in silicon/FPGA without a simulator testbench.

Parameters:
- WIDTH, 1, operand width of A and B driven to the comparator.
- SETTLE, 1, cycles each vector is held before its outputs are sampled; legal range 1..255.
- ERR_W, 8, width of err_count; the count saturates at its maximum.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep.
- a_out  out  WIDTH  operand A to the comparator.
- b_out  out  WIDTH  operand B to the comparator.
- gtr_in  in  1  comparator GTR (A>B).
- eq_in  in  1  comparator EQ (A==B).
- less_in  in  1  comparator LESS (A<B).
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until the next accepted start or reset.
- pass  out  1  done && err_count==0.
- err_count  out  ERR_W  number of mismatching vectors, saturating.
- fail_valid  out  1  at least one mismatch captured.
- fail_a  out  WIDTH  A of the first failing vector.
- fail_b  out  WIDTH  B of the first failing vector.
- fail_got  out  3  {gtr,eq,less} sampled at the first failure.

Behaviour:
- Reset (rst_n=0 at a clk edge, including mid-sweep):
  - state <= IDLE.
  - All outputs <= 0: a_out, b_out, busy, done, pass, err_count, fail_*.
  - Internal vector index and settle counter <= 0.
- States: IDLE, RUN, DONE.
- Vector order: index i runs 0..2^(2*WIDTH)-1, with a_out = i[2W-1:W] and b_out = i[W-1:0]. For WIDTH=1 this gives 00, 01, 10, 11.
- Expected result: {gtr,eq,less} = 100 if a>b, 010 if a==b, 001 if a<b (unsigned compare).
- IDLE or DONE, start=1 at an edge:
  - Go to RUN; busy<=1, done<=0.
  - err_count and all fail_* <= 0.
  - index<=0, so a_out/b_out <= 0, 0 at the same edge; settle counter <= 1.
- RUN:
  - The current vector is held for exactly SETTLE cycles.
  - At the edge where settle counter == SETTLE, the comparator inputs are sampled (pre-edge values) and compared against the expected result of the currently driven vector.
  - Mismatch: err_count increments, saturating at 2^ERR_W-1. If fail_valid==0, capture fail_a, fail_b, fail_got and set fail_valid<=1.
  - Later mismatches never overwrite the first-fail capture.
  - On that same edge, if the index is not the last, the index increments, a_out/b_out take the next vector and the settle counter <= 1. Otherwise go to DONE.
- Timing: a sweep occupies exactly 2^(2W)*SETTLE cycles from the start edge to the DONE edge.
- DONE:
  - busy<=0, done<=1, pass = (err_count==0).
  - a_out/b_out keep the last vector.
- start while in RUN is ignored; it does not restart the sweep.
- A non-one-hot comparator output (e.g. 000, 110) is always a mismatch.
- Reset wins over start if both are asserted at the same edge.

Optional Feature:
- Macro: COMP_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the sweep at that sampling edge. The FSM enters DONE with err_count=1, fail_* captured and a_out/b_out frozen on the failing vector.
- Undefined: the sweep always runs every vector; err_count totals all mismatches.

Test Plan:
- Correct comparator model, WIDTH=1, SETTLE=1; pulse start:
  - a_out/b_out step through 00, 01, 10, 11 on consecutive cycles, with busy=1 for 4 cycles.
  - Then done=1, pass=1, err_count=0, fail_valid=0.
- Comparator with eq_in stuck 0, WIDTH=1, macro off:
  - err_count=2, pass=0, fail_valid=1.
  - fail_a=0, fail_b=0, fail_got=000.
- Same faulty model with COMP_BIST_STOP_ON_FAIL_EN: done after 1 cycle, err_count=1, a_out=0, b_out=0.
- WIDTH=2, SETTLE=3, correct model:
  - done exactly 48 cycles after the start edge.
  - Each vector is held 3 cycles; last vector a=3, b=3; pass=1.
- Timing of start and reset:
  - A start pulse mid-sweep causes no restart and no change in vector sequence.
  - rst_n=0 mid-sweep sets all outputs to 0 and state to IDLE at the next edge.
  - A new start then runs a clean sweep.
- Saturation: ERR_W=2, WIDTH=1, comparator outputs inverted (all vectors wrong) -> err_count=3 (saturated), fail_a=0, fail_b=0, fail_got=101.
